// File: rtl/xillybus_mem_pkg.sv
// Shared definitions for the Xillybus seekable memory endpoint.
//   rd_state_t    : read-side FSM states
//   SEEK_HOLD_LEN : cycles (pulse + trailing) during which strobes are ignored
//   ram_addr_w()  : RAM index width for a given depth (never below 1)
package xillybus_mem_pkg;

  typedef enum logic [1:0] {
    R_CLOSED = 2'd0,
    R_ACTIVE = 2'd1,
    R_END    = 2'd2
  } rd_state_t;

  localparam int unsigned SEEK_HOLD_LEN = 2;

  function automatic int ram_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/xillybus_mem_ram.sv
// Simple dual-port RAM, DATA_W x DEPTH, no reset.
//   clk          : write and read clock
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : synchronous read port, latency 1, read-first on collision;
//                    rdata holds when re is low
module xillybus_mem_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both non-blocking: a read at the written address sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/xillybus_mem_port.sv
// User-side endpoint for the Xillybus seekable memory stream pair.
// Independent read/write pointers, both loaded by seek, auto-increment per access.
// Build option: define XILLY_MEM_EOF_EN for file-like end-of-memory semantics
// (read reaches R_END/eof, write stays full at DEPTH); otherwise pointers wrap.
//   bus_clk, trn_reset_n             : clock, async active-low reset
//   user_r_mem_rden/data/empty/eof/open : read stream
//   user_w_mem_wren/data/full/open   : write stream
//   user_mem_addr, user_mem_addr_update : seek
module xillybus_mem_port
  import xillybus_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              bus_clk,
  input  logic              trn_reset_n,
  input  logic              user_r_mem_rden,
  output logic [DATA_W-1:0] user_r_mem_data,
  output logic              user_r_mem_empty,
  output logic              user_r_mem_eof,
  input  logic              user_r_mem_open,
  input  logic              user_w_mem_wren,
  input  logic [DATA_W-1:0] user_w_mem_data,
  output logic              user_w_mem_full,
  input  logic              user_w_mem_open,
  input  logic [ADDR_W-1:0] user_mem_addr,
  input  logic              user_mem_addr_update
);

  localparam int PW  = ADDR_W + 1;
  localparam int RAW = ram_addr_w(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  rd_state_t         state, state_nx;
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_base, wr_base, rd_next, wr_next, seek_ptr;
  logic [1:0]        seek_cnt;
  logic              r_open_q, w_open_q, open_rise, seek_hold;
  logic              rd_acc, wr_acc, wr_at_end, data_valid;
  logic [DATA_W-1:0] ram_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
`ifdef XILLY_MEM_EOF_EN
    return p + 1'b1;
`else
    return (p == DEPTH_P - 1'b1) ? '0 : p + 1'b1;
`endif
  endfunction

  always_comb begin
    open_rise = (user_r_mem_open & ~r_open_q) | (user_w_mem_open & ~w_open_q);
    seek_hold = user_mem_addr_update | (seek_cnt != 2'd0);

    // An open edge zeroes the pointers this cycle, so accesses in that cycle
    // already use address 0.
    rd_base = open_rise ? '0 : rd_ptr;
    wr_base = open_rise ? '0 : wr_ptr;

    if ({1'b0, user_mem_addr} >= DEPTH_P) begin
`ifdef XILLY_MEM_EOF_EN
      seek_ptr = DEPTH_P;
`else
      seek_ptr = '0;
`endif
    end else begin
      seek_ptr = {1'b0, user_mem_addr};
    end

`ifdef XILLY_MEM_EOF_EN
    wr_at_end      = (wr_base >= DEPTH_P);
    user_r_mem_eof = (state == R_END);
`else
    wr_at_end      = 1'b0;
    user_r_mem_eof = 1'b0;
`endif

    user_r_mem_empty = seek_hold | (state != R_ACTIVE);
    user_w_mem_full  = ~trn_reset_n | ~user_w_mem_open | seek_hold | wr_at_end;
    rd_acc = user_r_mem_rden & ~user_r_mem_empty;
    wr_acc = user_w_mem_wren & ~user_w_mem_full;

    rd_next = user_mem_addr_update ? seek_ptr : (rd_acc ? ptr_inc(rd_base) : rd_base);
    wr_next = user_mem_addr_update ? seek_ptr : (wr_acc ? ptr_inc(wr_base) : wr_base);

    // State is frozen on the seek pulse and re-evaluated from the loaded
    // pointer at the edge that ends the hold.
    state_nx = state;
    if (!user_r_mem_open) begin
      state_nx = R_CLOSED;
    end else if (!user_mem_addr_update) begin
`ifdef XILLY_MEM_EOF_EN
      state_nx = (rd_next >= DEPTH_P) ? R_END : R_ACTIVE;
`else
      state_nx = R_ACTIVE;
`endif
    end
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state      <= R_CLOSED;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      seek_cnt   <= '0;
      r_open_q   <= 1'b0;
      w_open_q   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_next;
      r_open_q <= user_r_mem_open;
      w_open_q <= user_w_mem_open;
      if (user_mem_addr_update)  seek_cnt <= 2'(SEEK_HOLD_LEN - 1);
      else if (seek_cnt != 2'd0) seek_cnt <= seek_cnt - 2'd1;
      if (rd_acc) data_valid <= 1'b1;
    end
  end

  // The RAM output register has no reset; data_valid supplies the reset value.
  assign user_r_mem_data = data_valid ? ram_q : '0;

  xillybus_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAW)
  ) u_ram (
    .clk   (bus_clk),
    .we    (wr_acc),
    .waddr (wr_base[RAW-1:0]),
    .wdata (user_w_mem_data),
    .re    (rd_acc),
    .raddr (rd_base[RAW-1:0]),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_xillybus_mem_port.sv
module tb_xillybus_mem_port;

  logic       bus_clk = 1'b0;
  logic       trn_reset_n;
  logic       rden, r_open, wren, w_open, addr_update;
  logic [7:0] rdata, wdata;
  logic       empty, eof, full;
  logic [4:0] addr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 bus_clk = ~bus_clk;

  xillybus_mem_port #(
    .DATA_W (8),
    .ADDR_W (5),
    .DEPTH  (20)
  ) dut (
    .bus_clk              (bus_clk),
    .trn_reset_n          (trn_reset_n),
    .user_r_mem_rden      (rden),
    .user_r_mem_data      (rdata),
    .user_r_mem_empty     (empty),
    .user_r_mem_eof       (eof),
    .user_r_mem_open      (r_open),
    .user_w_mem_wren      (wren),
    .user_w_mem_data      (wdata),
    .user_w_mem_full      (full),
    .user_w_mem_open      (w_open),
    .user_mem_addr        (addr),
    .user_mem_addr_update (addr_update)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic seek(input logic [4:0] a);
    addr = a;
    addr_update = 1'b1;
    tick();
    addr_update = 1'b0;
    tick();
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    check(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic wr(input logic [7:0] d);
    wren  = 1'b1;
    wdata = d;
    tick();
    wren  = 1'b0;
  endtask

  initial begin
    trn_reset_n = 1'b0;
    {rden, r_open, wren, w_open, addr_update} = '0;
    wdata = '0;
    addr  = '0;

    // Reset state
    #2;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd1);
    check("rst_eof",   32'(eof),   32'd0);
    check("rst_data",  32'(rdata), 32'd0);
    tick();
    trn_reset_n = 1'b1;
    tick();

    // Fill memory with 0xA0+i
    w_open = 1'b1;
    tick();
    seek(5'd0);
    check("wr_full_open", 32'(full), 32'd0);
    for (int i = 0; i < 20; i++) wr(8'(8'hA0 + i));

    // Read back after a read-open edge
    w_open = 1'b0;
    #1 check("wr_full_closed", 32'(full), 32'd1);
    r_open = 1'b1;
    tick();
    check("rd_empty_open", 32'(empty), 32'd0);
    for (int i = 0; i < 20; i++) rd($sformatf("rd_seq%0d", i), 8'(8'hA0 + i));
    tick();
    check("rd_hold", 32'(rdata), 32'hB3);

    // Seek hold: writes and reads on the pulse and next cycle are dropped
    w_open = 1'b1;
    tick();
    addr = 5'd5; addr_update = 1'b1; wren = 1'b1; wdata = 8'h11;
    #1 check("hold_full0", 32'(full), 32'd1);
    check("hold_empty0", 32'(empty), 32'd1);
    tick();
    addr_update = 1'b0; wdata = 8'h22; rden = 1'b1;
    #1 check("hold_full1", 32'(full), 32'd1);
    check("hold_empty1", 32'(empty), 32'd1);
    tick();
    wren = 1'b0; rden = 1'b0;
    #1 check("hold_full2", 32'(full), 32'd0);
    check("hold_rd_ignored", 32'(rdata), 32'hB3);
    wr(8'h33);
    seek(5'd4);
    rd("hold_m4", 8'hA4);
    rd("hold_m5", 8'h33);
    rd("hold_m6", 8'hA6);

`ifdef XILLY_MEM_EOF_EN
    seek(5'd18);
    rd("eof_m18", 8'hB2);
    rd("eof_m19", 8'hB3);
    check("eof_flag", 32'(eof), 32'd1);
    check("eof_empty", 32'(empty), 32'd1);
    rd("eof_rd_dropped", 8'hB3);
    seek(5'd19);
    check("eof_wr_open", 32'(full), 32'd0);
    check("eof_cleared", 32'(eof), 32'd0);
    wr(8'h77);
    check("eof_wr_full", 32'(full), 32'd1);
    wr(8'h78);
    seek(5'd19);
    rd("eof_m19_new", 8'h77);
    seek(5'd25);
    check("eof_seek_big", 32'(eof), 32'd1);
    check("eof_seek_big_full", 32'(full), 32'd1);
`else
    seek(5'd19);
    rd("wrap_m19", 8'hB3);
    rd("wrap_m0", 8'hA0);
    rd("wrap_m1", 8'hA1);
    check("wrap_eof", 32'(eof), 32'd0);
    seek(5'd25);
    check("wrap_full", 32'(full), 32'd0);
    rd("wrap_seek25", 8'hA0);
`endif

    // Same-address collision returns the old word
    seek(5'd7);
    wr(8'hAA);
    seek(5'd7);
    rden = 1'b1; wren = 1'b1; wdata = 8'h55;
    tick();
    rden = 1'b0; wren = 1'b0;
    check("coll_old", 32'(rdata), 32'hAA);
    seek(5'd7);
    rd("coll_new", 8'h55);

    // Reset in the middle of a write burst
    seek(5'd0);
    wr(8'h60); wr(8'h61); wr(8'h62);
    wren = 1'b1; wdata = 8'h63;
    trn_reset_n = 1'b0;
    #1 check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full", 32'(full), 32'd1);
    check("mid_rst_data", 32'(rdata), 32'd0);
    tick();
    tick();
    wren = 1'b0; r_open = 1'b0; w_open = 1'b0;
    trn_reset_n = 1'b1;
    tick();
    r_open = 1'b1; w_open = 1'b1;
    tick();
    check("post_rst_empty", 32'(empty), 32'd0);
    rd("post_rst_m0", 8'h60);
    rd("post_rst_m1", 8'h61);
    rd("post_rst_m2", 8'h62);
    rd("post_rst_m3", 8'hA3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
